// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response channel between instruction fetch and data access.
// Data has priority over fetch, with a starvation guard; an in-order tracker routes each response back to its requester.
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_addr_valid,
  output logic        inst_addr_ready,
  input  logic [31:0] inst_addr,
  output logic        inst_line_valid,
  input  logic        inst_line_ready,
  output logic [31:0] inst_line,
  input  logic        inst_flush,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic [31:0] data_req_addr,
  input  logic        data_req_we,
  input  logic [3:0]  data_req_be,
  input  logic [31:0] data_req_wdata,
  output logic        data_resp_valid,
  input  logic        data_resp_ready,
  output logic [31:0] data_resp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_rdata
);

  localparam int unsigned  PW      = $clog2(MAX_OUTSTANDING);
  localparam int unsigned  CW      = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] DEPTH   = CW'(MAX_OUTSTANDING);
  localparam logic [3:0]    LIMIT   = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {FREE, HOLD_I, HOLD_D} state_e;

  state_e                     state_q, state_d;
  logic                       active_q;
  logic [3:0]                 starve_q, starve_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] src_q, src_d, stale_q, stale_d;

  logic full, empty, grant_i, grant_d, req_valid, push, pop, resp_ready;
  logic head_src, head_stale;

  assign full       = (count_q == DEPTH);
  assign empty      = (count_q == '0);
  assign head_src   = src_q[rd_ptr_q];
  assign head_stale = stale_q[rd_ptr_q];

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      HOLD_I:  grant_i = 1'b1;
      HOLD_D:  grant_d = 1'b1;
      default: begin
        if (data_req_valid && !(inst_addr_valid && starve_q == LIMIT)) grant_d = 1'b1;
        else if (inst_addr_valid)                                        grant_i = 1'b1;
      end
    endcase
  end

  assign req_valid = active_q & ~full &
                     ((grant_i & inst_addr_valid) | (grant_d & data_req_valid));
  assign push      = req_valid & mem_req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (req_valid && !mem_req_ready) state_d = grant_d ? HOLD_D : HOLD_I;
      end
      default: begin
        if (push) state_d = FREE;
      end
    endcase
  end

  assign mem_req_valid   = req_valid;
  assign inst_addr_ready = active_q & grant_i & mem_req_ready & ~full;
  assign data_req_ready  = active_q & grant_d & mem_req_ready & ~full;

  always_comb begin
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_be    = '0;
    mem_req_wdata = '0;
    if (active_q && grant_d) begin
      mem_req_addr  = data_req_addr;
      mem_req_we    = data_req_we;
      mem_req_be    = data_req_be;
      mem_req_wdata = data_req_wdata;
    end else if (active_q && grant_i) begin
      mem_req_addr  = inst_addr;
      mem_req_be    = '1;
    end
  end

  // Stale inst beats are drained silently; a flush in the same cycle also drops a live head beat.
  always_comb begin
    inst_line_valid = 1'b0;
    data_resp_valid = 1'b0;
    resp_ready      = 1'b0;
    if (active_q && !empty) begin
      if (head_src) begin
        data_resp_valid = mem_resp_valid;
        resp_ready      = data_resp_ready;
      end else if (head_stale) begin
        resp_ready      = 1'b1;
      end else begin
        inst_line_valid = mem_resp_valid & ~inst_flush;
        resp_ready      = inst_line_ready | inst_flush;
      end
    end
  end

  assign mem_resp_ready  = resp_ready;
  assign pop             = mem_resp_valid & resp_ready;
  assign inst_line       = active_q ? mem_resp_rdata : '0;
  assign data_resp_rdata = active_q ? mem_resp_rdata : '0;

  always_comb begin
    starve_d = starve_q;
    if (!inst_addr_valid || (push && grant_i)) starve_d = '0;
    else if (push && grant_d && starve_q != LIMIT) starve_d = starve_q + 4'd1;
  end

  always_comb begin
    src_d    = src_q;
    stale_d  = stale_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (inst_flush) stale_d = stale_q | ~src_q;
    if (push) begin
      src_d[wr_ptr_q]   = grant_d;
      stale_d[wr_ptr_q] = grant_i & inst_flush;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FREE;
      active_q <= 1'b0;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      src_q    <= '0;
      stale_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      src_q    <= src_d;
      stale_q  <= stale_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model (queues of outstanding
// requests, held owner, starvation count) predicts every handshake and routed data word.
module tb_mem_port_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned L = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inst_addr_valid = 0, inst_addr_ready, inst_line_valid, inst_line_ready = 0, inst_flush = 0;
  logic [31:0] inst_addr = '0, inst_line;
  logic data_req_valid = 0, data_req_ready, data_req_we = 0, data_resp_valid, data_resp_ready = 0;
  logic [31:0] data_req_addr = '0, data_req_wdata = '0, data_resp_rdata;
  logic [3:0] data_req_be = '0, mem_req_be;
  logic mem_req_valid, mem_req_ready = 0, mem_req_we, mem_resp_valid = 0, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = '0;

  mem_port_arbiter #(.MAX_OUTSTANDING(N), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .inst_addr_valid(inst_addr_valid), .inst_addr_ready(inst_addr_ready), .inst_addr(inst_addr),
    .inst_line_valid(inst_line_valid), .inst_line_ready(inst_line_ready), .inst_line(inst_line),
    .inst_flush(inst_flush),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_req_addr(data_req_addr),
    .data_req_we(data_req_we), .data_req_be(data_req_be), .data_req_wdata(data_req_wdata),
    .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready), .data_resp_rdata(data_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct {bit src; bit stale; logic [31:0] data;} ent_t;
  ent_t        trk[$];
  logic [31:0] memq[$];
  int          starve = 0, held = 0;
  int          n_cmp = 0, n_err = 0;
  int          p_iv, p_dv, p_mrr, p_mrv, p_ilr, p_drr, p_fl, p_spur;
  int unsigned inst_k = 0;
  bit          i_x = 0, d_x = 0;
  bit          chk_starve = 0, streak_ok = 0;
  int          streak = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit rnd(input int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a, input logic we);
    return {a[15:0], a[31:16]} ^ (we ? 32'hACC0_0000 : 32'h1357_9BDF);
  endfunction

  task automatic set_knobs(input int iv, dv, mrr, mrv, ilr, drr, fl, spur);
    p_iv = iv; p_dv = dv; p_mrr = mrr; p_mrv = mrv;
    p_ilr = ilr; p_drr = drr; p_fl = fl; p_spur = spur;
  endtask

  task automatic check_quiet(input string tag, input bit with_data);
    check_eq({tag, "_hs"}, {26'd0, mem_req_valid, inst_addr_ready, data_req_ready,
                            inst_line_valid, data_resp_valid, mem_resp_ready}, '0);
    if (with_data) begin
      check_eq({tag, "_addr"}, mem_req_addr, '0);
      check_eq({tag, "_line"}, inst_line, '0);
      check_eq({tag, "_rdata"}, data_resp_rdata, '0);
    end
  endtask

  task automatic run_cycle();
    int owner;
    bit full, e_rq, e_rr, e_ilv, e_dv, rx, sx;
    ent_t e;
    @(negedge clk);
    if (i_x) inst_addr_valid = 0;
    if (d_x) data_req_valid = 0;
    if (!inst_addr_valid && rnd(p_iv)) begin
      inst_addr_valid = 1; inst_addr = 32'hBFC0_0000 + 4 * inst_k; inst_k++;
    end
    if (!data_req_valid && rnd(p_dv)) begin
      data_req_valid = 1; data_req_addr = $urandom; data_req_we = 1'($urandom);
      data_req_be = 4'($urandom); data_req_wdata = $urandom;
    end
    mem_req_ready   = rnd(p_mrr);
    inst_line_ready = rnd(p_ilr);
    data_resp_ready = rnd(p_drr);
    inst_flush      = rnd(p_fl);
    if (memq.size() > 0) begin
      mem_resp_valid = rnd(p_mrv); mem_resp_rdata = memq[0];
    end else begin
      mem_resp_valid = rnd(p_spur); mem_resp_rdata = $urandom;
    end
    #1;
    full = (trk.size() == int'(N));
    if (held != 0) owner = held;
    else if (data_req_valid && !(inst_addr_valid && starve == int'(L))) owner = 2;
    else if (inst_addr_valid) owner = 1;
    else owner = 0;
    e_rq = !full && ((owner == 1 && inst_addr_valid) || (owner == 2 && data_req_valid));
    check_eq("mem_req_valid", mem_req_valid, e_rq);
    check_eq("inst_addr_ready", inst_addr_ready, owner == 1 && mem_req_ready && !full);
    check_eq("data_req_ready", data_req_ready, owner == 2 && mem_req_ready && !full);
    if (e_rq && owner == 2) begin
      check_eq("req_addr_d", mem_req_addr, data_req_addr);
      check_eq("req_ctl_d", {mem_req_we, mem_req_be}, {data_req_we, data_req_be});
      check_eq("req_wdata_d", mem_req_wdata, data_req_wdata);
    end else if (e_rq) begin
      check_eq("req_addr_i", mem_req_addr, inst_addr);
      check_eq("req_we_i", mem_req_we, 1'b0);
    end
    e_ilv = 0; e_dv = 0; e_rr = 0;
    if (trk.size() > 0) begin
      if (trk[0].src) begin e_dv = mem_resp_valid; e_rr = data_resp_ready; end
      else if (trk[0].stale) e_rr = 1;
      else begin e_ilv = mem_resp_valid && !inst_flush; e_rr = inst_line_ready || inst_flush; end
    end
    check_eq("mem_resp_ready", mem_resp_ready, e_rr);
    check_eq("inst_line_valid", inst_line_valid, e_ilv);
    check_eq("data_resp_valid", data_resp_valid, e_dv);
    if (e_ilv) check_eq("inst_line", inst_line, trk[0].data);
    if (e_dv)  check_eq("data_resp_rdata", data_resp_rdata, trk[0].data);

    @(posedge clk);
    rx = e_rq && mem_req_ready;
    sx = mem_resp_valid && e_rr;
    i_x = rx && owner == 1;
    d_x = rx && owner == 2;
    if (sx) begin e = trk.pop_front(); void'(memq.pop_front()); end
    if (inst_flush)
      foreach (trk[i]) if (!trk[i].src) begin e = trk[i]; e.stale = 1; trk[i] = e; end
    if (rx) begin
      e.src   = (owner == 2);
      e.stale = (owner == 1) && inst_flush;
      e.data  = (owner == 2) ? mem_data(data_req_addr, data_req_we) : mem_data(inst_addr, 1'b0);
      trk.push_back(e);
      memq.push_back(e.data);
    end
    if (chk_starve) begin
      if (d_x) streak++;
      if (i_x) begin
        if (streak_ok) check_eq("starve_run", streak, L);
        streak = 0; streak_ok = 1;
      end
    end
    if (!inst_addr_valid || i_x) starve = 0;
    else if (d_x && starve < int'(L)) starve++;
    if (rx) held = 0;
    else if (held == 0 && e_rq) held = owner;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
    #3 check_quiet("rst_init", 1);
    @(negedge clk);
    inst_addr_valid = 1; inst_addr = 32'hBFC0_0000; inst_k = 1;
    mem_req_ready = 1;
    #2 rst = 1;
    #1 check_quiet("rst_release", 0);

    set_knobs(100, 0, 100, 100, 100, 100, 0, 0);   run(30);
    set_knobs(100, 0, 100, 0, 100, 100, 0, 0);     run(8);
    set_knobs(0, 0, 100, 100, 100, 100, 0, 0);     run(10);
    chk_starve = 1; streak_ok = 0; streak = 0;
    set_knobs(100, 100, 100, 100, 100, 100, 0, 0); run(60);
    chk_starve = 0;
    set_knobs(70, 70, 30, 80, 80, 80, 0, 0);       run(100);
    set_knobs(80, 40, 70, 60, 70, 70, 25, 0);      run(300);
    set_knobs(50, 50, 50, 50, 50, 50, 10, 30);     run(800);

    set_knobs(100, 100, 100, 0, 100, 100, 0, 0);
    for (int i = 0; i < 50 && trk.size() < 2; i++) run_cycle();
    check_eq("prefill", 32'(trk.size() >= 2), 1);
    @(negedge clk);
    #2 rst = 0;
    #1 check_quiet("rst_mid", 1);
    trk.delete(); memq.delete();
    starve = 0; held = 0; i_x = 0; d_x = 0;
    inst_addr_valid = 1; inst_addr = 32'hBFC0_0000 + 4 * inst_k; inst_k++;
    data_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1;
    repeat (2) @(negedge clk);
    #1 check_quiet("rst_hold", 1);
    #1 rst = 1;
    #1 check_quiet("rst_release2", 0);
    set_knobs(60, 60, 70, 60, 70, 70, 10, 20);     run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory request/response channel between the instruction-fetch path and the data-access path. Arbitrates request issue with data priority and a starvation guard, and tracks up to MAX_OUTSTANDING in-flight requests in issue order so each response returns to its owner. It also discards instruction responses made stale by a fetch redirect. Sits between inst_fetch / the load-store unit and the cache/bus interface.

## Interface
- MAX_OUTSTANDING, 4, depth of the in-order tracker (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive lost inst arbitrations before inst is forced to win (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- inst_addr_valid  in  1  fetch request valid
- inst_addr_ready  out  1  fetch request accepted
- inst_addr  in  32  fetch address
- inst_line_valid  out  1  fetch response valid
- inst_line_ready  in  1  fetch response accepted
- inst_line  out  32  fetch response data
- inst_flush  in  1  fetch redirect; in-flight inst responses become stale
- data_req_valid / data_req_ready  in / out  1  data request handshake
- data_req_addr  in  32; data_req_we  in  1; data_req_be  in  4; data_req_wdata  in  32
- data_resp_valid / data_resp_ready  out / in  1  data response handshake (writes return one ack beat)
- data_resp_rdata  out  32
- mem_req_valid / mem_req_ready  out / in  1  shared request handshake
- mem_req_addr  out  32; mem_req_we  out  1; mem_req_be  out  4; mem_req_wdata  out  32
- mem_resp_valid / mem_resp_ready  in / out  1  shared response handshake; exactly one beat per request, in issue order
- mem_resp_rdata  in  32

## Operation
- Transfer on any channel = valid & ready in the same cycle.
- Tracker: circular FIFO of MAX_OUTSTANDING entries {src (0=inst, 1=data), stale}, plus an occupancy count of width log2(MAX_OUTSTANDING)+1. Push on a mem request transfer; pop on a mem response transfer. New requests issue only while count < MAX_OUTSTANDING, with no same-cycle pop credit. Pointers wrap modulo depth.
- Arbiter states: FREE, HOLD_I, HOLD_D.
  - In FREE, the winner is chosen combinationally. Data wins if data_req_valid, unless inst_addr_valid and starve_cnt == STARVE_LIMIT, in which case inst wins. Otherwise inst wins if inst_addr_valid.
  - If the winner presents mem_req_valid and mem_req_ready=0, go to HOLD_I or HOLD_D.
  - In a HOLD state, the grant is fixed to that owner. Return to FREE on transfer.
  - mem_req_* fields are muxed from the granted source. They must stay stable while held; requesters are required to keep their request stable while valid.
- starve_cnt (4 bits): increments when inst_addr_valid and data wins a transfer. Clears on any inst transfer or when inst_addr_valid=0. Saturates at STARVE_LIMIT.
- inst_addr_ready = grant_inst & mem_req_ready & ~full. data_req_ready is the same with grant_data. mem_req_valid = granted valid & ~full.
- Response routing by tracker head:
  - Head src=1: data_resp_valid = mem_resp_valid, mem_resp_ready = data_resp_ready.
  - Head src=0, not stale: inst_line_valid = mem_resp_valid & ~inst_flush, mem_resp_ready = inst_line_ready | inst_flush.
  - Head stale: mem_resp_ready=1, both response valids low, beat dropped.
  - mem_resp_valid with an empty tracker is a protocol error: beat is ignored, mem_resp_ready=0.
- inst_flush: sets stale on every valid src=0 entry. An inst request pushed in the flush cycle is pushed stale. Data entries are never affected.

## Timing
- Request and response paths are combinational pass-through: 0-cycle latency, no added bubbles.
- Throughput: one request and one response per cycle, concurrently.
- Reset (rst=0, async): tracker empty, pointers 0, state FREE, starve_cnt 0.
  - All ready/valid outputs are 0 during reset and low until the first clk edge after release.
  - Data outputs are 0.
- Reset mid-operation drops all tracking. Requesters and memory are reset together.
- Full (count == MAX_OUTSTANDING): no issue. A response pop in that cycle re-enables issue next cycle.
- Empty tracker with a simultaneous push: the response cannot arrive before the next cycle, so no bypass is needed.

## Test plan
- Reset release, inst only: 6 back-to-back fetches 0xBFC00000+4k with memory ready=1 and 1-cycle response -> inst_line returns matching data in order; count never exceeds MAX_OUTSTANDING. With responses withheld, the 5th request stalls with inst_addr_ready=0.
- Both requesters always valid -> data wins 8 consecutive transfers, then inst wins once (starve_cnt==8), then starve_cnt clears and the pattern repeats.
- Mixed outstanding: issue I0, D0 (we=1, be=4'b0011), I1 -> responses route inst, data ack, inst in order. Holding data_resp_ready=0 back-pressures mem_resp_ready.
- mem_req_ready=0 for 3 cycles on a data grant while inst raises valid -> grant stays data (HOLD_D), mem_req_addr stable, inst issues on the following cycle.
- Three inst requests outstanding, pulse inst_flush together with a new inst request -> all four responses consumed with inst_line_valid=0. A data response queued behind them is delivered normally.
- Assert rst=0 asynchronously mid-burst with two entries outstanding -> outputs drop immediately; after release the tracker is empty and the first new request routes correctly.
